prio_req_encoder: RTL and testbench

Parametrised, registered priority encoder for N request lines. Incoming requests are captured into a sticky pending register, and masked requests are excluded. The winning index is presented on a valid/ready output port, and an accepted grant clears its pending bit. Priority is either fixed (lowest index wins) or round-robin, selected at run time. The block replaces the fixed 4-input combinational encoder wherever requesters need arbitration, buffering of short pulses, or back-pressure.

---
 rtl/prio_req_encoder.sv | 98 +++++++++
 tb/tb_prio_req_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_req_encoder.sv
// Registered priority encoder with sticky pending requests, per-line masking,
// run-time fixed/round-robin selection and a valid/ready grant port.
module prio_req_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         any
);

    logic [N-1:0] r_pending;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic         w_free;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_elig;
    logic         w_fix_hit;
    logic [W-1:0] w_fix_idx;
    logic         w_rr_hit;
    logic [W-1:0] w_rr_idx;
    logic [W-1:0] w_win;

    // Index visited at step k of a round-robin search that begins just after p.
    function automatic logic [W-1:0] rr_wrap(input logic [W-1:0] p, input int k);
        int s;
        s = int'(p) + 1 + k;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    assign w_accept = r_valid & out_ready;
    assign w_free   = ~r_valid | w_accept;
    assign w_clr    = w_accept ? (N'(1) << r_idx) : '0;
    // The line being accepted this cycle is excluded so it cannot be granted twice.
    assign w_elig   = r_pending & mask & ~w_clr;

    always_comb begin
        w_fix_hit = 1'b0;
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_fix_hit && w_elig[i]) begin
                w_fix_hit = 1'b1;
                w_fix_idx = W'(i);
            end
        end
    end

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_rr_hit && w_elig[rr_wrap(r_ptr, k)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = rr_wrap(r_ptr, k);
            end
        end
    end

    assign w_win = mode ? w_rr_idx : w_fix_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= W'(N - 1);
        end else begin
            // A new request on the line being cleared keeps its pending bit.
            r_pending <= (r_pending & ~w_clr) | req;
            if (w_accept) r_ptr <= r_idx;
            if (w_free) begin
                if (|w_elig) begin
                    r_valid <= 1'b1;
                    r_idx   <= w_win;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign pending   = r_pending;
    assign any       = |(r_pending & mask);

endmodule

// File: tb/tb_prio_req_encoder.sv
// Self-checking bench for prio_req_encoder: directed scenarios plus a random
// run, all compared against a behavioural model of the arbitration rules.
module tb_prio_req_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         any;

    int total = 0;
    int bad   = 0;

    // Behavioural model state and its next-cycle values
    logic [N-1:0] m_pend = '0;
    bit           m_valid = 1'b0;
    int           m_idx = 0;
    int           m_ptr = N - 1;
    logic [N-1:0] n_pend;
    bit           n_valid;
    int           n_idx;
    int           n_ptr;

    prio_req_encoder #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .pending(pending), .any(any)
    );

    always #5 clk = ~clk;

    task automatic model_next();
        logic [N-1:0] clr;
        logic [N-1:0] cand;
        bit acc;
        acc = m_valid && out_ready;
        clr = '0;
        if (acc) clr[m_idx] = 1'b1;
        if (rst) begin
            n_pend = '0; n_valid = 1'b0; n_idx = 0; n_ptr = N - 1;
            return;
        end
        n_pend  = (m_pend & ~clr) | req;
        n_valid = m_valid;
        n_idx   = m_idx;
        n_ptr   = acc ? m_idx : m_ptr;
        if (!m_valid || acc) begin
            cand    = m_pend & mask & ~clr;
            n_valid = (cand != 0);
            if (cand != 0) begin
                if (!mode) begin
                    for (int i = N - 1; i >= 0; i--) if (cand[i]) n_idx = i;
                end else begin
                    for (int k = N; k >= 1; k--) if (cand[(m_ptr + k) % N]) n_idx = (m_ptr + k) % N;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_next();
        @(posedge clk);
        #1;
        m_pend = n_pend; m_valid = n_valid; m_idx = n_idx; m_ptr = n_ptr;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mask = '1; mode = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mask = '1; mode = 1'b1; out_ready = 1'b1;
        req = N'($urandom);
        step();
        req = N'($urandom);
        step();
        rst = 1'b0; req = '0;
        total++; if (pending !== '0) begin bad++; $display("FAIL rst_pending got=%0h exp=0", pending); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        total++; if (out_idx !== '0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", out_idx); end
        total++; if (any !== 1'b0) begin bad++; $display("FAIL rst_any got=%0b exp=0", any); end
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1; req = 8'b0001_0100;
        step();
        req = '0;
        total++; if (pending !== 8'h14 || out_valid !== 1'b0) begin bad++; $display("FAIL lat_t1 pend=%0h vld=%0b exp pend=14 vld=0", pending, out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd2) begin bad++; $display("FAIL lat_t2 vld=%0b idx=%0d exp vld=1 idx=2", out_valid, out_idx); end
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd4) begin bad++; $display("FAIL lat_t3 vld=%0b idx=%0d exp vld=1 idx=4", out_valid, out_idx); end
        step();
        total++; if (out_valid !== 1'b0 || pending !== '0) begin bad++; $display("FAIL lat_t4 vld=%0b pend=%0h exp vld=0 pend=0", out_valid, pending); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h20;
        step();
        req = '0;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd5) begin bad++; $display("FAIL bp_grant vld=%0b idx=%0d exp vld=1 idx=5", out_valid, out_idx); end
        req = 8'h01; mask = 8'hDF;
        step();
        req = '0; mode = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd5) begin bad++; $display("FAIL bp_hold vld=%0b idx=%0d exp vld=1 idx=5", out_valid, out_idx); end
        mode = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin bad++; $display("FAIL bp_next vld=%0b idx=%0d exp vld=1 idx=0", out_valid, out_idx); end
        total++; if (pending !== 8'h01) begin bad++; $display("FAIL bp_pend got=%0h exp=01", pending); end
        mask = '1;
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1; out_ready = 1'b1; req = 8'hFF;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_idx !== W'(k % N)) begin bad++; $display("FAIL rr_seq%0d vld=%0b idx=%0d exp vld=1 idx=%0d", k, out_valid, out_idx, k % N); end
        end
        do_reset();
        mode = 1'b0; out_ready = 1'b1; req = 8'hFF;
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (out_valid !== m_valid || out_idx !== m_idx[W-1:0]) begin bad++; $display("FAIL fix_seq%0d vld=%0b idx=%0d exp vld=%0b idx=%0d", k, out_valid, out_idx, m_valid, m_idx); end
        end
        req = '0;
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h08;
        step();
        req = '0;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin bad++; $display("FAIL col_grant vld=%0b idx=%0d exp vld=1 idx=3", out_valid, out_idx); end
        out_ready = 1'b1; req = 8'h08;
        step();
        req = '0;
        total++; if (pending[3] !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL col_keep pend=%0h vld=%0b exp pend[3]=1 vld=0", pending, out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin bad++; $display("FAIL col_regrant vld=%0b idx=%0d exp vld=1 idx=3", out_valid, out_idx); end
        step();
        total++; if (pending[3] !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL col_clear pend=%0h vld=%0b exp pend[3]=0 vld=0", pending, out_valid); end
    endtask

    task automatic test_masking();
        do_reset();
        mask = 8'h80; req = 8'h81; out_ready = 1'b1;
        step();
        req = '0;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd7) begin bad++; $display("FAIL msk_grant vld=%0b idx=%0d exp vld=1 idx=7", out_valid, out_idx); end
        step();
        total++; if (out_valid !== 1'b0 || pending !== 8'h01 || any !== 1'b0) begin bad++; $display("FAIL msk_held vld=%0b pend=%0h any=%0b exp vld=0 pend=01 any=0", out_valid, pending, any); end
        mask = 8'hFF;
        #1;
        total++; if (any !== 1'b1) begin bad++; $display("FAIL msk_any got=%0b exp=1", any); end
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin bad++; $display("FAIL msk_unmask vld=%0b idx=%0d exp vld=1 idx=0", out_valid, out_idx); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 1'b1; req = 8'hF0;
        step();
        req = '0;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending !== 8'hF0) begin bad++; $display("FAIL mr_pre vld=%0b idx=%0d pend=%0h exp vld=1 idx=4 pend=F0", out_valid, out_idx, pending); end
        rst = 1'b1; req = 8'h01;
        step();
        rst = 1'b0; req = '0;
        total++; if (pending !== '0 || out_valid !== 1'b0 || out_idx !== '0 || any !== 1'b0) begin bad++; $display("FAIL mr_clear pend=%0h vld=%0b idx=%0d any=%0b exp all 0", pending, out_valid, out_idx, any); end
        out_ready = 1'b1; req = 8'h81;
        step();
        req = '0;
        step();
        total++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin bad++; $display("FAIL mr_rr vld=%0b idx=%0d exp vld=1 idx=0", out_valid, out_idx); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) mask = N'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%0h exp=%0h", c, pending, m_pend); end
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, m_valid); end
            total++; if (out_idx !== m_idx[W-1:0]) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, out_idx, m_idx); end
            total++; if (any !== |(m_pend & mask)) begin bad++; $display("FAIL rnd_any c=%0d got=%0b exp=%0b", c, any, |(m_pend & mask)); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; mask = '1; mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_round_robin();
        test_collision();
        test_masking();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
